// File: rtl/shared_divider.sv
// shared_divider: two-client restoring radix-2 divider with Busy/Ready handshake; optional rounding via DIV_ROUND_EN
module shared_divider #(
   parameter int WIDTH_div = 16,
   parameter int CNT_W     = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 select,
   input  logic [WIDTH_div-1:0] dividend0,
   input  logic [WIDTH_div-1:0] divisor0,
   input  logic [WIDTH_div-1:0] dividend1,
   input  logic [WIDTH_div-1:0] divisor1,
   output logic [WIDTH_div-1:0] dividerres,
   output logic                 Busy,
   output logic                 Ready,
   output logic                 div_zero
);
`ifdef DIV_ROUND_EN
   typedef enum logic [1:0] {IDLE, RUN, ROUND} state_t;
`else
   typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif
   state_t               state;
   logic [WIDTH_div-1:0] dvd, dsr, rem, quo, rem_nx, quo_nx;
   logic [WIDTH_div:0]   rem_sh;
   logic [CNT_W-1:0]     cnt;
   logic                 ge, last, dz;
   // the shifted partial remainder needs one extra bit; after subtraction it always fits the divisor width
   assign rem_sh = {rem, dvd[WIDTH_div-1]};
   assign ge     = rem_sh >= {1'b0, dsr};
   assign rem_nx = ge ? rem_sh[WIDTH_div-1:0] - dsr : rem_sh[WIDTH_div-1:0];
   assign quo_nx = {quo[WIDTH_div-2:0], ge};
   assign last   = cnt == CNT_W'(WIDTH_div - 1);
   assign dz     = dsr == '0;
`ifdef DIV_ROUND_EN
   logic                 up;
   logic [WIDTH_div-1:0] quo_rnd;
   // round half up on the final remainder, saturating at all ones
   assign up      = {1'b0, rem, 1'b0} >= {2'b00, dsr};
   assign quo_rnd = (up && quo != '1) ? quo + 1'b1 : quo;
`endif
   // control FSM, datapath registers and registered handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         dvd        <= '0;
         dsr        <= '0;
         rem        <= '0;
         quo        <= '0;
         cnt        <= '0;
         dividerres <= '0;
         Busy       <= 1'b0;
         Ready      <= 1'b0;
         div_zero   <= 1'b0;
      end else begin
         Ready <= 1'b0;
         case (state)
            IDLE: if (start) begin
               dvd   <= select ? dividend1 : dividend0;
               dsr   <= select ? divisor1 : divisor0;
               rem   <= '0;
               quo   <= '0;
               cnt   <= '0;
               Busy  <= 1'b1;
               state <= RUN;
            end
            RUN: begin
               dvd <= {dvd[WIDTH_div-2:0], 1'b0};
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt + CNT_W'(1);
               if (last) begin
`ifdef DIV_ROUND_EN
                  state <= ROUND;
`else
                  dividerres <= dz ? '1 : quo_nx;
                  div_zero   <= dz;
                  Busy       <= 1'b0;
                  Ready      <= 1'b1;
                  state      <= IDLE;
`endif
               end
            end
`ifdef DIV_ROUND_EN
            ROUND: begin
               dividerres <= dz ? '1 : quo_rnd;
               div_zero   <= dz;
               Busy       <= 1'b0;
               Ready      <= 1'b1;
               state      <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_shared_divider.sv
// tb_shared_divider: randomized self-checking bench for shared_divider against an arithmetic model
module tb_shared_divider;
   localparam int W = 16;
`ifdef DIV_ROUND_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = W;
`endif
   logic         clk = 1'b0;
   logic         rst, start, select;
   logic [W-1:0] dividend0, divisor0, dividend1, divisor1, dividerres;
   logic         Busy, Ready, div_zero;
   int           checks = 0, errors = 0, n = 0;
   logic [W-1:0] exp_q;
   logic         exp_z, seen;

   always #5 clk = ~clk;

   shared_divider dut (
      .clk(clk), .rst(rst), .start(start), .select(select),
      .dividend0(dividend0), .divisor0(divisor0),
      .dividend1(dividend1), .divisor1(divisor1),
      .dividerres(dividerres), .Busy(Busy), .Ready(Ready), .div_zero(div_zero)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      int unsigned q, r;
      if (b == 0) return '1;
      q = a / b;
      r = a % b;
`ifdef DIV_ROUND_EN
      if (2 * r >= b && q < 32'hFFFF) q++;
`endif
      return W'(q);
   endfunction

   task automatic step();
      @(negedge clk);
      n++;
      if (Busy && Ready) chk("busy_ready_overlap", {30'd0, Busy, Ready}, 32'd0);
   endtask

   task automatic issue(input logic sel, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1);
      select = sel; dividend0 = a0; divisor0 = b0; dividend1 = a1; divisor1 = b1; start = 1'b1;
      exp_q = sel ? model(a1, b1) : model(a0, b0);
      exp_z = (sel ? b1 : b0) == 0;
      @(posedge clk);
      n = 0;
      @(negedge clk);
      start = 1'b0;
      chk("busy_rise", 32'(Busy), 32'd1);
      chk("ready_low", 32'(Ready), 32'd0);
      select = 1'($urandom); dividend0 = W'($urandom); divisor0 = W'($urandom);
      dividend1 = W'($urandom); divisor1 = W'($urandom);
   endtask

   task automatic wait_done();
      while (!Ready && n < 3 * W) step();
      chk("latency", 32'(n), 32'(LAT));
      chk("result", 32'(dividerres), 32'(exp_q));
      chk("div_zero", 32'(div_zero), 32'(exp_z));
      chk("busy_off", 32'(Busy), 32'd0);
   endtask

   task automatic ready_drop();
      step();
      chk("ready_pulse", 32'(Ready), 32'd0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; select = 1'b0;
      dividend0 = '0; divisor0 = '0; dividend1 = '0; divisor1 = '0;
      #2 rst = 1'b1;
      #1;
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_ready", 32'(Ready), 32'd0);
      chk("rst_res", 32'(dividerres), 32'd0);
      chk("rst_dz", 32'(div_zero), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(1'b0, 16'd36000, 16'd100, W'($urandom), W'($urandom));
      wait_done(); ready_drop();
      issue(1'b1, 16'd1234, 16'd55, 16'd1000, 16'd7);
      wait_done(); ready_drop();
      issue(1'b0, 16'd1234, 16'd0, 16'd9, 16'd3);
      wait_done(); ready_drop();
      issue(1'b0, 16'd500, 16'd5, 16'd0, 16'd0);
      wait_done(); ready_drop();
      issue(1'b0, 16'd7, 16'd2, 16'd100, 16'd3);
      repeat (4) step();
      start = 1'b1; select = 1'b1; dividend0 = 16'd900; divisor0 = 16'd1;
      step();
      start = 1'b0;
      wait_done();
      issue(1'b0, 16'hFFFF, 16'd1, W'($urandom), W'($urandom));
      wait_done();
      issue(1'b0, 16'd5, 16'd9, W'($urandom), W'($urandom));
      wait_done(); ready_drop();
      repeat (20) begin
         logic [W-1:0] a0, b0, a1, b1;
         a0 = W'($urandom); a1 = W'($urandom);
         b0 = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
         b1 = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
         issue(1'($urandom), a0, b0, a1, b1);
         wait_done();
      end
      ready_drop();
      issue(1'b0, 16'd40000, 16'd3, 16'd0, 16'd0);
      repeat (7) step();
      #1 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(Busy), 32'd0);
      chk("arst_ready", 32'(Ready), 32'd0);
      chk("arst_res", 32'(dividerres), 32'd0);
      chk("arst_dz", 32'(div_zero), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (25) begin
         step();
         seen = seen | Ready | Busy;
      end
      chk("idle_after_rst", 32'(seen), 32'd0);
      issue(1'b1, 16'd3, 16'd3, 16'd60000, 16'd250);
      wait_done(); ready_drop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
